// File: rtl/serial_link_pkg.sv
// Shared definitions for the single-wire serial link (transmitter and receiver).
// PAR is only reachable when PISO_PARITY_EN is defined.
package serial_link_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PAR,
      STOP
   } tx_state_t;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/piso_serial_tx_if.sv
// Load handshake and serial line bundle for piso_serial_tx.
// slave = transmitter side, master = upstream producer / line observer.
interface piso_serial_tx_if #(
   parameter int unsigned WIDTH = 8
);

   logic             load_valid;
   logic             load_ready;
   logic [WIDTH-1:0] load_data;
   logic             sdata;
   logic             sframe;
   logic             done;

   modport master (
      output load_valid,
      output load_data,
      input  load_ready,
      input  sdata,
      input  sframe,
      input  done
   );

   modport slave (
      input  load_valid,
      input  load_data,
      output load_ready,
      output sdata,
      output sframe,
      output done
   );

endinterface

// File: rtl/piso_serial_tx.sv
// Parallel-in/serial-out framer: start bit, WIDTH data bits, optional even parity, stop bit.
// Define PISO_PARITY_EN to insert the parity bit after the last data bit.
module piso_serial_tx
   import serial_link_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input logic              clk,
   input logic              clear,
   piso_serial_tx_if.slave  tx
);

   localparam int unsigned      CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);

   tx_state_t        state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CW-1:0]    count_q, count_d;
   logic             sdata_q, sdata_d;
   logic             sframe_q, sframe_d;
   logic             done_q, done_d;
`ifdef PISO_PARITY_EN
   logic             parity_q, parity_d;
`endif

   logic             load_ready;
   logic             accept;
   logic             head;
   logic [WIDTH-1:0] shifted;

   assign load_ready    = (state_q == IDLE) || (state_q == STOP);
   assign accept        = tx.load_valid && load_ready;
   assign tx.load_ready = load_ready;
   assign tx.sdata      = sdata_q;
   assign tx.sframe     = sframe_q;
   assign tx.done       = done_q;

   // The register always holds the bit to send next at its head; it is shifted
   // in the same cycle that bit is registered onto sdata.
   always_comb begin
      if (MSB_FIRST) begin
         head    = shift_q[WIDTH-1];
         shifted = {shift_q[WIDTH-2:0], 1'b0};
      end else begin
         head    = shift_q[0];
         shifted = {1'b0, shift_q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (!clear) begin
         state_q  <= IDLE;
         shift_q  <= '0;
         count_q  <= '0;
         sdata_q  <= LINE_IDLE;
         sframe_q <= 1'b0;
         done_q   <= 1'b0;
`ifdef PISO_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         count_q  <= count_d;
         sdata_q  <= sdata_d;
         sframe_q <= sframe_d;
         done_q   <= done_d;
`ifdef PISO_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      count_d  = count_q;
`ifdef PISO_PARITY_EN
      parity_d = parity_q;
`endif
      unique case (state_q)
         IDLE, STOP: begin
            if (accept) begin
               state_d  = START;
               shift_d  = tx.load_data;
               count_d  = '0;
`ifdef PISO_PARITY_EN
               parity_d = ^tx.load_data;
`endif
            end else begin
               state_d = IDLE;
            end
         end
         START: begin
            state_d = DATA;
            shift_d = shifted;
            count_d = '0;
         end
         DATA: begin
            if (count_q == LAST) begin
`ifdef PISO_PARITY_EN
               state_d = PAR;
`else
               state_d = STOP;
`endif
            end else begin
               count_d = count_q + CW'(1);
               shift_d = shifted;
            end
         end
         PAR:     state_d = STOP;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they are registered with it.
   always_comb begin
      sdata_d  = LINE_IDLE;
      sframe_d = 1'b0;
      done_d   = 1'b0;
      case (state_d)
         START: sdata_d = START_BIT;
         DATA: begin
            sdata_d  = head;
            sframe_d = 1'b1;
         end
`ifdef PISO_PARITY_EN
         PAR: begin
            sdata_d  = parity_q;
            sframe_d = 1'b1;
         end
`endif
         STOP: begin
            sdata_d = STOP_BIT;
            done_d  = 1'b1;
         end
         default: sdata_d = LINE_IDLE;
      endcase
   end

endmodule

// File: tb/tb_piso_serial_tx.sv
// Self-checking bench for piso_serial_tx: an MSB-first and an LSB-first instance, per-cycle line scoreboard.
// Build with PISO_PARITY_EN defined to expect the parity bit in every frame.
module tb_piso_serial_tx;

   typedef struct {
      int unsigned sel;       // 0: MSB-first DUT, 1: LSB-first DUT
      logic [7:0]  word;
      logic [7:0]  exp_bits;  // data bits in line order, [7] sent first
      logic        exp_par;
      bit          keep;      // leave load_valid high after capture
   } vec_t;

   // {sdata, sframe, done, load_ready}
   typedef logic [3:0] line_t;
   localparam line_t IDLE_LINE = 4'b1001;

   logic clk = 1'b0;
   logic clear0, clear1;
   bit   mon_en = 1'b0;
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   line_t q0[$];
   line_t q1[$];
   vec_t  vecs[9];

   always #5 clk = ~clk;

   piso_serial_tx_if #(.WIDTH(8)) if0 ();
   piso_serial_tx_if #(.WIDTH(8)) if1 ();

   piso_serial_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut0 (.clk(clk), .clear(clear0), .tx(if0));
   piso_serial_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut1 (.clk(clk), .clear(clear1), .tx(if1));

   task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      line_t e;
      if (mon_en) begin
         e = (q0.size() != 0) ? q0.pop_front() : IDLE_LINE;
         cmp("dut0_line", {4'b0, if0.sdata, if0.sframe, if0.done, if0.load_ready}, {4'b0, e});
         e = (q1.size() != 0) ? q1.pop_front() : IDLE_LINE;
         cmp("dut1_line", {4'b0, if1.sdata, if1.sframe, if1.done, if1.load_ready}, {4'b0, e});
      end
   end

   function automatic logic get_ready(input int unsigned sel);
      return (sel == 0) ? if0.load_ready : if1.load_ready;
   endfunction

   task automatic push(input int unsigned sel, input line_t e);
      if (sel == 0) q0.push_back(e);
      else          q1.push_back(e);
   endtask

   // Called #1 after a posedge; returns #1 after the capturing edge.
   task automatic send(input vec_t v);
      int unsigned k;
      if (v.sel == 0) begin
         if0.load_valid = 1'b1;
         if0.load_data  = v.word;
      end else begin
         if1.load_valid = 1'b1;
         if1.load_data  = v.word;
      end
      k = 0;
      while (!get_ready(v.sel) && k < 100) begin
         @(posedge clk);
         #1;
         k++;
      end
      if (!get_ready(v.sel)) begin
         n_cmp++;
         n_bad++;
         $display("FAIL ready_timeout dut%0d: got load_ready=0 expected 1 within 100 cycles", v.sel);
      end
      @(posedge clk);
      push(v.sel, 4'b0000);
      for (int i = 7; i >= 0; i--) push(v.sel, {v.exp_bits[i], 3'b100});
`ifdef PISO_PARITY_EN
      push(v.sel, {v.exp_par, 3'b100});
`endif
      push(v.sel, 4'b1011);
      #1;
      if (!v.keep) begin
         if (v.sel == 0) if0.load_valid = 1'b0;
         else            if1.load_valid = 1'b0;
      end
      // Post-capture data change must not disturb the frame in flight.
      if (v.sel == 0) if0.load_data = ~v.word;
      else            if1.load_data = ~v.word;
   endtask

   initial begin
      vec_t mid;
      int unsigned k;

      vecs[0] = '{sel: 0, word: 8'hA5, exp_bits: 8'b1010_0101, exp_par: 1'b0, keep: 1'b0};
      vecs[1] = '{sel: 1, word: 8'h01, exp_bits: 8'b1000_0000, exp_par: 1'b1, keep: 1'b0};
      vecs[2] = '{sel: 0, word: 8'hFF, exp_bits: 8'b1111_1111, exp_par: 1'b0, keep: 1'b1};
      vecs[3] = '{sel: 0, word: 8'h00, exp_bits: 8'b0000_0000, exp_par: 1'b0, keep: 1'b0};
      vecs[4] = '{sel: 1, word: 8'h07, exp_bits: 8'b1110_0000, exp_par: 1'b1, keep: 1'b0};
      vecs[5] = '{sel: 1, word: 8'h03, exp_bits: 8'b1100_0000, exp_par: 1'b0, keep: 1'b0};
      vecs[6] = '{sel: 0, word: 8'h07, exp_bits: 8'b0000_0111, exp_par: 1'b1, keep: 1'b0};
      vecs[7] = '{sel: 1, word: 8'hA5, exp_bits: 8'b1010_0101, exp_par: 1'b0, keep: 1'b0};
      vecs[8] = '{sel: 0, word: 8'h3C, exp_bits: 8'b0011_1100, exp_par: 1'b0, keep: 1'b0};

      // Reset held with load_valid asserted: nothing may be captured.
      clear0 = 1'b0;
      clear1 = 1'b0;
      if0.load_valid = 1'b1;
      if1.load_valid = 1'b1;
      if0.load_data  = 8'h5A;
      if1.load_data  = 8'h5A;
      @(posedge clk);
      mon_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      clear0 = 1'b1;
      clear1 = 1'b1;
      if0.load_valid = 1'b0;
      if1.load_valid = 1'b0;
      @(negedge clk);
      cmp("reset_ready0", {7'b0, if0.load_ready}, 8'd1);
      cmp("reset_ready1", {7'b0, if1.load_ready}, 8'd1);
      @(posedge clk);
      #1;

      foreach (vecs[i]) send(vecs[i]);

      // Reset while the 4th data bit is on the line abandons the frame.
      k = 0;
      while ((q0.size() != 0 || q1.size() != 0) && k < 200) begin
         @(posedge clk);
         k++;
      end
      #1;
      mid = '{sel: 0, word: 8'hA5, exp_bits: 8'b1010_0101, exp_par: 1'b0, keep: 1'b0};
      send(mid);
      repeat (4) @(posedge clk);
      #1;
      clear0 = 1'b0;
      @(posedge clk);
      q0.delete();
      #1;
      clear0 = 1'b1;
      @(negedge clk);
      cmp("midreset_ready", {7'b0, if0.load_ready}, 8'd1);
      cmp("midreset_sdata", {7'b0, if0.sdata}, 8'd1);
      cmp("midreset_done", {7'b0, if0.done}, 8'd0);

      k = 0;
      while ((q0.size() != 0 || q1.size() != 0) && k < 200) begin
         @(posedge clk);
         k++;
      end
      cmp("queues_drained", {7'b0, (q0.size() == 0 && q1.size() == 0)}, 8'd1);
      repeat (4) @(posedge clk);
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
